// File: rtl/td4_sequencer.sv
// TD4 4-bit CPU control unit: fetch/exec/writeback sequencer that owns
// pc, A, B, the output port and the carry flag.
module td4_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] rom_addr,
  output logic [3:0] out_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic       carry,
  output logic       busy,
  output logic       instr_done,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_e;

  typedef enum logic [2:0] {
    DST_NONE = 3'd0,
    DST_A    = 3'd1,
    DST_B    = 3'd2,
    DST_OUT  = 3'd3,
    DST_JMP  = 3'd4,
    DST_JNC  = 3'd5
  } dst_e;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       carry_q, carry_d;
  logic       halted_q, halted_d;
  logic [7:0] ir_q, ir_d;
  logic [4:0] sum_q, sum_d;

  src_e       src_sel;
  dst_e       dst_sel;
  logic [3:0] src_val;
  logic [3:0] imm;
  logic       jump_taken;
  logic       halt_now;

  assign imm = ir_q[3:0];

  // Opcode decode of the latched instruction; unlisted opcodes are NOPs.
  always_comb begin
    src_sel = SRC_ZERO;
    dst_sel = DST_NONE;
    case (ir_q[7:4])
      4'b0000: begin src_sel = SRC_A;    dst_sel = DST_A;   end
      4'b0001: begin src_sel = SRC_B;    dst_sel = DST_A;   end
      4'b0010: begin src_sel = SRC_IN;   dst_sel = DST_A;   end
      4'b0011: begin src_sel = SRC_ZERO; dst_sel = DST_A;   end
      4'b0100: begin src_sel = SRC_A;    dst_sel = DST_B;   end
      4'b0101: begin src_sel = SRC_B;    dst_sel = DST_B;   end
      4'b0110: begin src_sel = SRC_IN;   dst_sel = DST_B;   end
      4'b0111: begin src_sel = SRC_ZERO; dst_sel = DST_B;   end
      4'b1001: begin src_sel = SRC_B;    dst_sel = DST_OUT; end
      4'b1011: begin src_sel = SRC_ZERO; dst_sel = DST_OUT; end
      4'b1110: begin src_sel = SRC_ZERO; dst_sel = DST_JNC; end
      4'b1111: begin src_sel = SRC_ZERO; dst_sel = DST_JMP; end
      default: begin src_sel = SRC_ZERO; dst_sel = DST_NONE; end
    endcase
  end

  always_comb begin
    src_val = 4'd0;
    case (src_sel)
      SRC_A:    src_val = a_q;
      SRC_B:    src_val = b_q;
      SRC_IN:   src_val = in_port;
      default:  src_val = 4'd0;
    endcase
  end

  // JNC looks at carry_q, which still holds the flag from before this instruction.
  assign jump_taken = (dst_sel == DST_JMP) || ((dst_sel == DST_JNC) && !carry_q);
  assign halt_now   = (dst_sel == DST_JMP) && (sum_q[3:0] == pc_q);

  // run is a level (keep executing), step a single-cycle request that is only
  // honoured in IDLE; neither is queued, and halted blocks both.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    a_d        = a_q;
    b_d        = b_q;
    out_d      = out_q;
    carry_d    = carry_q;
    halted_d   = halted_q;
    ir_d       = ir_q;
    sum_d      = sum_q;
    instr_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((run || step) && !halted_q) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = rom_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        sum_d   = {1'b0, src_val} + {1'b0, imm};
        state_d = S_WB;
      end
      S_WB: begin
        instr_done = 1'b1;
        case (dst_sel)
          DST_A:   a_d   = sum_q[3:0];
          DST_B:   b_d   = sum_q[3:0];
          DST_OUT: out_d = sum_q[3:0];
          default: ;
        endcase
        carry_d = (dst_sel == DST_NONE) ? 1'b0 : sum_q[4];
        pc_d    = jump_taken ? sum_q[3:0] : (pc_q + 4'd1);
        if (halt_now) begin
          halted_d = 1'b1;
          state_d  = S_IDLE;
        end else if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= 4'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      out_q    <= 4'd0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
      ir_q     <= 8'd0;
      sum_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
      ir_q     <= ir_d;
      sum_q    <= sum_d;
    end
  end

  assign rom_addr = pc_q;
  assign out_port = out_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign carry    = carry_q;
  assign halted   = halted_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/td4_sequencer.md
# td4_sequencer

Multi-cycle control unit for the TD4 4-bit CPU. Fetches 8-bit instructions from an external combinational ROM, decodes them, and sequences execution. Owns the architectural state: program counter, registers A and B, the output port, and the carry flag. Supports free-run and single-step operation, and sits between the program ROM and the board I/O.

## Interface
- No parameters (all widths are fixed by the TD4 ISA).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 = execute instructions back-to-back.
- `step`  in  1  one-cycle pulse; executes one instruction when idle and `run`=0.
- `rom_data`  in  8  instruction at `rom_addr`; `[7:4]` opcode, `[3:0]` immediate.
- `in_port`  in  4  input switches.
- `rom_addr`  out  4  equal to `pc` at all times.
- `out_port`  out  4  output LED register.
- `reg_a`, `reg_b`  out  4 each  architectural registers (debug visibility).
- `carry`  out  1  carry flag.
- `busy`  out  1  high while an instruction is in flight (FETCH, EXEC or WB).
- `instr_done`  out  1  one-cycle pulse in the WB cycle.
- `halted`  out  1  sticky; set by a JMP to its own address.

## Operation
- Reset: `pc`, `reg_a`, `reg_b`, `out_port`, `carry`, `halted` and the IR all go to 0; `instr_done`=0; state goes to IDLE.
- FSM states: IDLE → FETCH → EXEC → WB → (FETCH if `run`=1 and !`halted`, else IDLE).
- IDLE → FETCH when (`run`=1 or `step`=1) and `halted`=0.
- FETCH: latch `rom_data` into IR.
- EXEC: select the source operand and form a 5-bit sum = source + immediate, zero-extended.
- WB: write the destination, update carry and pc, pulse `instr_done`.
- Decode (opcode → source, destination):
  - 0000 ADD A,Im → src A, dst A.
  - 0001 MOV A,B → src B, dst A.
  - 0010 IN A → src `in_port`, dst A.
  - 0011 MOV A,Im → src 0, dst A.
  - 0100 MOV B,A → src A, dst B.
  - 0101 MOV B,B → src B, dst B.
  - 0110 IN B → src `in_port`, dst B.
  - 0111 MOV B,Im → src 0, dst B.
  - 1001 OUT B → src B, dst OUT.
  - 1011 OUT Im → src 0, dst OUT.
  - 1110 JNC Im → src 0, dst PC only if `carry`=0 (the value before this instruction); otherwise no write.
  - 1111 JMP Im → src 0, dst PC.
  - 1000, 1010, 1100, 1101 → NOP, no write.
- Destination receives sum[3:0]. The MOV forms therefore add Im (e.g. MOV A,B computes B+Im).
- Carry at WB: `carry` <= sum[4] for every instruction, including jumps (always 0 there); NOPs clear `carry`.
- PC at WB: jump target if a jump is taken, else pc+1 mod 16 (15 wraps to 0).
- Halt: a taken JMP (1111 only) whose target equals the current pc sets `halted`, and the FSM returns to IDLE. Only `rst` clears `halted`.

## Timing
- 3 cycles per instruction; `instr_done` is asserted during WB, and register/flag updates are visible the cycle after WB.
- Free run: a new FETCH follows WB immediately, giving one instruction per 3 cycles.
- `step` is sampled only in IDLE. Pulses while `busy`=1, while `run`=1, or while `halted`=1 are ignored (not queued).
- `run` falling mid-instruction: the current instruction completes, then the FSM goes to IDLE.
- `rst` asserted in any state overrides everything on that edge; no partial writes occur.
- `rom_data` must be stable in the FETCH cycle; it is ignored in all other cycles.
- `in_port` is sampled in the EXEC cycle.

## Test plan
- Reset: assert `rst` mid-EXEC of `ADD A,5` with A=3. After the edge, A=0, pc=0, `carry`=0, `busy`=0.
- Carry/JNC: ROM `MOV A,15; ADD A,1; JNC 0; OUT 9`. Expect A=0 with `carry`=1 after the ADD; the JNC is not taken; `out_port`=9 at pc 3; `carry`=0 after the OUT.
- Free run: ROM `OUT 1; ADD A,1; JMP 1` with `run`=1. `instr_done` pulses every 3 cycles and A increments once per loop iteration.
- Single step: `run`=0, three `step` pulses, each sent while `busy`=1 except the first. Exactly one instruction executes and pc=1.
- Halt: program `JMP 4` located at address 4. `halted`=1 and the FSM stays in IDLE despite `run`=1 and `step` pulses; `rst` clears it.
- Wrap/NOP: 16 NOPs (opcode 1000) in free run. pc goes 15→0, no register changes, `carry` stays 0.
